// File: rtl/pipeline_control_if.sv
// Bundle of hazard, redirect, cache handshake and pipeline-enable signals
// exchanged between the central pipeline controller and the datapath.
interface pipeline_control_if #(
  parameter int CNT_W = 32
);

  // Operand information of the instruction sitting in ID
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;

  // Instruction sitting in EX
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_br_redirect;

  // Cache handshakes
  logic             if_req;
  logic             imem_resp;
  logic             mem_req;
  logic             dmem_resp;
  logic             imem_read;
  logic             dmem_go;

  // Pipeline register control
  logic             load_pc;
  logic             load_if_id;
  logic             load_id_ex;
  logic             load_ex_mem;
  logic             load_mem_wb;
  logic             bubble_id_ex;
  logic             flush_if_id;
  logic             stall;

  // Performance counters
  logic [CNT_W-1:0] cnt_mem_stall;
  logic [CNT_W-1:0] cnt_load_use;
  logic [CNT_W-1:0] cnt_flush;

  // Controller side: observes pipeline state, drives enables and counters
  modport master (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_mem_read, ex_rd, ex_br_redirect,
    input  if_req, imem_resp, mem_req, dmem_resp,
    output imem_read, dmem_go,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    output bubble_id_ex, flush_if_id, stall,
    output cnt_mem_stall, cnt_load_use, cnt_flush
  );

  // Datapath side: reports pipeline state, obeys enables
  modport slave (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_mem_read, ex_rd, ex_br_redirect,
    output if_req, imem_resp, mem_req, dmem_resp,
    input  imem_read, dmem_go,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    input  bubble_id_ex, flush_if_id, stall,
    input  cnt_mem_stall, cnt_load_use, cnt_flush
  );

endinterface

// File: rtl/pipeline_control.sv
// Central stall/flush controller for the 5-stage RV32I pipeline.
// Arbitrates I-/D-cache waits, inserts the load-use bubble, squashes the
// wrong path on EX redirects and keeps three saturating event counters.
module pipeline_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_control_if.master ctl
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Latched "response already received" flags for the current stall episode
  logic             i_done_q, i_done_d;
  logic             d_done_q, d_done_d;

  // Performance counter state
  logic [CNT_W-1:0] cnt_mem_stall_q, cnt_mem_stall_d;
  logic [CNT_W-1:0] cnt_load_use_q,  cnt_load_use_d;
  logic [CNT_W-1:0] cnt_flush_q,     cnt_flush_d;

  // Per-cycle decision terms
  logic             i_done;
  logic             d_done;
  logic             advance;
  logic             load_use;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             ev_stall;
  logic             ev_load_use;
  logic             ev_flush;

  // Hazard detection and memory completion terms
  always_comb begin
    rs1_hit  = ctl.id_uses_rs1 && (ctl.id_rs1 == ctl.ex_rd);
    rs2_hit  = ctl.id_uses_rs2 && (ctl.id_rs2 == ctl.ex_rd);
    load_use = ctl.ex_mem_read && (ctl.ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    i_done   = ctl.imem_resp || i_done_q || !ctl.if_req;
    d_done   = ctl.dmem_resp || d_done_q || !ctl.mem_req;
    advance  = i_done && d_done;
  end

  // Pipeline enables, bubble/flush selection and cache request gating
  always_comb begin
    ctl.imem_read    = 1'b0;
    ctl.dmem_go      = 1'b0;
    ctl.load_pc      = 1'b0;
    ctl.load_if_id   = 1'b0;
    ctl.load_id_ex   = 1'b0;
    ctl.load_ex_mem  = 1'b0;
    ctl.load_mem_wb  = 1'b0;
    ctl.bubble_id_ex = 1'b0;
    ctl.flush_if_id  = 1'b0;
    ctl.stall        = 1'b0;
    ev_stall         = 1'b0;
    ev_load_use      = 1'b0;
    ev_flush         = 1'b0;
    if (!rst) begin
      ctl.imem_read = ctl.if_req && !i_done_q;
      ctl.dmem_go   = ctl.mem_req && !d_done_q;
      if (!advance) begin
        ctl.stall = 1'b1;
        ev_stall  = 1'b1;
      end else if (ctl.ex_br_redirect) begin
        ctl.load_pc      = 1'b1;
        ctl.load_if_id   = 1'b1;
        ctl.load_id_ex   = 1'b1;
        ctl.load_ex_mem  = 1'b1;
        ctl.load_mem_wb  = 1'b1;
        ctl.flush_if_id  = 1'b1;
        ctl.bubble_id_ex = 1'b1;
        ev_flush         = 1'b1;
      end else if (load_use) begin
        ctl.load_id_ex   = 1'b1;
        ctl.bubble_id_ex = 1'b1;
        ctl.load_ex_mem  = 1'b1;
        ctl.load_mem_wb  = 1'b1;
        ev_load_use      = 1'b1;
      end else begin
        ctl.load_pc      = 1'b1;
        ctl.load_if_id   = 1'b1;
        ctl.load_id_ex   = 1'b1;
        ctl.load_ex_mem  = 1'b1;
        ctl.load_mem_wb  = 1'b1;
      end
    end
  end

  // Response flags remember a served request while the other side still waits
  always_comb begin
    i_done_d = 1'b0;
    d_done_d = 1'b0;
    if (!advance) begin
      i_done_d = i_done;
      d_done_d = d_done;
    end
  end

  // Saturating counter next-state; increments stop at all-ones
  always_comb begin
    cnt_mem_stall_d = cnt_mem_stall_q;
    cnt_load_use_d  = cnt_load_use_q;
    cnt_flush_d     = cnt_flush_q;
    if (ev_stall && (cnt_mem_stall_q != CNT_MAX)) begin
      cnt_mem_stall_d = cnt_mem_stall_q + 1'b1;
    end
    if (ev_load_use && (cnt_load_use_q != CNT_MAX)) begin
      cnt_load_use_d = cnt_load_use_q + 1'b1;
    end
    if (ev_flush && (cnt_flush_q != CNT_MAX)) begin
      cnt_flush_d = cnt_flush_q + 1'b1;
    end
  end

  // State registers; reset discards any latched cache response
  always_ff @(posedge clk) begin
    if (rst) begin
      i_done_q        <= 1'b0;
      d_done_q        <= 1'b0;
      cnt_mem_stall_q <= '0;
      cnt_load_use_q  <= '0;
      cnt_flush_q     <= '0;
    end else begin
      i_done_q        <= i_done_d;
      d_done_q        <= d_done_d;
      cnt_mem_stall_q <= cnt_mem_stall_d;
      cnt_load_use_q  <= cnt_load_use_d;
      cnt_flush_q     <= cnt_flush_d;
    end
  end

  // Counters read as zero for the whole time reset is held
  always_comb begin
    ctl.cnt_mem_stall = rst ? '0 : cnt_mem_stall_q;
    ctl.cnt_load_use  = rst ? '0 : cnt_load_use_q;
    ctl.cnt_flush     = rst ? '0 : cnt_flush_q;
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control with an expectation queue.
module tb_pipeline_control;

  logic clk;
  logic rst;

  pipeline_control_if #(.CNT_W(32)) bus ();

  pipeline_control #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  typedef struct {
    logic       r;
    logic       ifReq;
    logic       iResp;
    logic       memReq;
    logic       dResp;
    logic       redirect;
    logic       memRead;
    logic [4:0] exRd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses1;
    logic       uses2;
  } stim_t;

  typedef struct {
    string      tag;
    logic [4:0] loads;
    logic       stall;
    logic       bubble;
    logic       flush;
    logic       imem;
    logic       dmem;
  } exp_t;

  exp_t scoreboard[$];
  int   assertCount = 0;
  int   failCount   = 0;

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t memStim(input logic r, ifq, ir, mq, dr, br);
    stim_t s;
    s.r = r; s.ifReq = ifq; s.iResp = ir; s.memReq = mq; s.dResp = dr;
    s.redirect = br; s.memRead = 1'b0; s.exRd = 5'd0; s.rs1 = 5'd0;
    s.rs2 = 5'd0; s.uses1 = 1'b0; s.uses2 = 1'b0;
    return s;
  endfunction

  function automatic exp_t mkExp(input string tag, input logic [4:0] l,
                                 input logic st, b, f, im, dm);
    exp_t e;
    e.tag = tag; e.loads = l; e.stall = st; e.bubble = b; e.flush = f;
    e.imem = im; e.dmem = dm;
    return e;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assertCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus just after the edge and queue its expectation
  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst                = s.r;
    bus.if_req         = s.ifReq;
    bus.imem_resp      = s.iResp;
    bus.mem_req        = s.memReq;
    bus.dmem_resp      = s.dResp;
    bus.ex_br_redirect = s.redirect;
    bus.ex_mem_read    = s.memRead;
    bus.ex_rd          = s.exRd;
    bus.id_rs1         = s.rs1;
    bus.id_rs2         = s.rs2;
    bus.id_uses_rs1    = s.uses1;
    bus.id_uses_rs2    = s.uses2;
    scoreboard.push_back(e);
  endtask

  // Sample at the falling edge and compare against the oldest expectation
  task automatic checkOutput();
    exp_t e;
    @(negedge clk);
    if (scoreboard.size() == 0) begin
      assertCount++;
      failCount++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = scoreboard.pop_front();
      checkValue({e.tag, ".loads"},  {27'd0, bus.load_pc, bus.load_if_id, bus.load_id_ex,
                                      bus.load_ex_mem, bus.load_mem_wb}, {27'd0, e.loads});
      checkValue({e.tag, ".stall"},  {31'd0, bus.stall},        {31'd0, e.stall});
      checkValue({e.tag, ".bubble"}, {31'd0, bus.bubble_id_ex}, {31'd0, e.bubble});
      checkValue({e.tag, ".flush"},  {31'd0, bus.flush_if_id},  {31'd0, e.flush});
      checkValue({e.tag, ".imem"},   {31'd0, bus.imem_read},    {31'd0, e.imem});
      checkValue({e.tag, ".dmem"},   {31'd0, bus.dmem_go},      {31'd0, e.dmem});
    end
  endtask

  task automatic checkCounters(input string tag, input logic [31:0] ms, lu, fl);
    checkValue({tag, ".cnt_mem_stall"}, bus.cnt_mem_stall, ms);
    checkValue({tag, ".cnt_load_use"},  bus.cnt_load_use,  lu);
    checkValue({tag, ".cnt_flush"},     bus.cnt_flush,     fl);
  endtask

  // Linear sequence of directed scenarios
  initial begin
    stim_t s;
    stim_t hit;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.imem_resp = 1'b0; bus.mem_req = 1'b0; bus.dmem_resp = 1'b0;
    bus.ex_br_redirect = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rd = 5'd0;
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;

    // Reset holds every output low even with live requests and a redirect
    s = memStim(1, 1, 1, 1, 1, 1);
    s.memRead = 1; s.exRd = 5'd4; s.rs1 = 5'd4; s.uses1 = 1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(s, mkExp("reset", 5'b00000, 0, 0, 0, 0, 0));
      checkOutput();
      checkCounters("reset", 0, 0, 0);
    end

    // Both caches hit every cycle with independent instructions
    hit = memStim(0, 1, 1, 1, 1, 0);
    s = hit;
    s.memRead = 1; s.exRd = 5'd7; s.rs1 = 5'd1; s.rs2 = 5'd2; s.uses1 = 1; s.uses2 = 1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(s, mkExp("hit", 5'b11111, 0, 0, 0, 1, 1));
      checkOutput();
    end
    checkCounters("hit", 0, 0, 0);

    // I response in cycle 3, D response in cycle 6
    for (int c = 0; c <= 6; c++) begin
      s = memStim(0, 1, c == 3, 1, c == 6, 0);
      applyStimulus(s, mkExp("imiss_dmiss", (c == 6) ? 5'b11111 : 5'b00000,
                             c < 6, 0, 0, c <= 3, 1));
      checkOutput();
      if (c == 3) checkCounters("imiss_dmiss_mid", 3, 0, 0);
      if (c == 6) checkCounters("imiss_dmiss_end", 6, 0, 0);
    end
    s = memStim(0, 0, 0, 0, 0, 0);
    applyStimulus(s, mkExp("idle", 5'b11111, 0, 0, 0, 0, 0));
    checkOutput();
    checkCounters("idle", 6, 0, 0);

    // Load-use on rs2 inserts one bubble, then forwarding takes over
    s = hit;
    s.memRead = 1; s.exRd = 5'd5; s.rs2 = 5'd5; s.uses2 = 1; s.rs1 = 5'd3; s.uses1 = 1;
    applyStimulus(s, mkExp("loaduse_rs2", 5'b00111, 0, 1, 0, 1, 1));
    checkOutput();
    applyStimulus(hit, mkExp("after_loaduse", 5'b11111, 0, 0, 0, 1, 1));
    checkOutput();
    checkCounters("after_loaduse", 6, 1, 0);

    // Load into x0 never stalls
    s = hit;
    s.memRead = 1; s.exRd = 5'd0; s.rs2 = 5'd0; s.uses2 = 1;
    applyStimulus(s, mkExp("loaduse_x0", 5'b11111, 0, 0, 0, 1, 1));
    checkOutput();

    // Matching rs1 that the instruction does not read is not a hazard
    s = hit;
    s.memRead = 1; s.exRd = 5'd9; s.rs1 = 5'd9; s.uses1 = 0;
    applyStimulus(s, mkExp("rs1_unused", 5'b11111, 0, 0, 0, 1, 1));
    checkOutput();
    s.uses1 = 1;
    applyStimulus(s, mkExp("loaduse_rs1", 5'b00111, 0, 1, 0, 1, 1));
    checkOutput();
    applyStimulus(hit, mkExp("after_rs1", 5'b11111, 0, 0, 0, 1, 1));
    checkOutput();
    checkCounters("after_rs1", 6, 2, 0);

    // Reset between scenarios clears the counters
    applyStimulus(memStim(1, 1, 0, 1, 0, 0), mkExp("reset2", 5'b00000, 0, 0, 0, 0, 0));
    checkOutput();
    checkCounters("reset2", 0, 0, 0);

    // Redirect together with a load-use hazard: redirect wins
    s = hit;
    s.redirect = 1; s.memRead = 1; s.exRd = 5'd5; s.rs2 = 5'd5; s.uses2 = 1;
    applyStimulus(s, mkExp("redirect_hazard", 5'b11111, 0, 1, 1, 1, 1));
    checkOutput();
    applyStimulus(hit, mkExp("after_redirect", 5'b11111, 0, 0, 0, 1, 1));
    checkOutput();
    checkCounters("after_redirect", 0, 0, 1);

    // Redirect held through a 4-cycle D miss flushes only on the response cycle
    for (int c = 0; c <= 4; c++) begin
      s = memStim(0, 1, c == 0, 1, c == 4, 1);
      applyStimulus(s, mkExp("redirect_dmiss", (c == 4) ? 5'b11111 : 5'b00000,
                             c < 4, c == 4, c == 4, c == 0, 1));
      checkOutput();
    end
    applyStimulus(memStim(0, 0, 0, 0, 0, 0), mkExp("after_dmiss", 5'b11111, 0, 0, 0, 0, 0));
    checkOutput();
    checkCounters("after_dmiss", 4, 0, 2);

    // Reset mid-stall after the I response was latched
    applyStimulus(memStim(0, 1, 1, 1, 0, 0), mkExp("rst_stall0", 5'b00000, 1, 0, 0, 1, 1));
    checkOutput();
    applyStimulus(memStim(0, 1, 0, 1, 0, 0), mkExp("rst_stall1", 5'b00000, 1, 0, 0, 0, 1));
    checkOutput();
    applyStimulus(memStim(1, 1, 0, 1, 0, 0), mkExp("rst_stall2", 5'b00000, 0, 0, 0, 0, 0));
    checkOutput();
    checkCounters("rst_stall2", 0, 0, 0);
    applyStimulus(memStim(0, 1, 0, 1, 0, 0), mkExp("rst_release", 5'b00000, 1, 0, 0, 1, 1));
    checkOutput();
    checkCounters("rst_release", 0, 0, 0);
    applyStimulus(memStim(0, 1, 1, 1, 1, 0), mkExp("rst_resume", 5'b11111, 0, 0, 0, 1, 1));
    checkOutput();
    checkCounters("rst_resume", 1, 0, 0);

    // Preload the stall counter one below all-ones, then stall three cycles
    force dut.cnt_mem_stall_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_mem_stall_q;
    s = memStim(0, 1, 0, 1, 0, 0);
    applyStimulus(s, mkExp("sat0", 5'b00000, 1, 0, 0, 1, 1));
    checkOutput();
    checkCounters("sat0", 32'hFFFF_FFFE, 0, 0);
    applyStimulus(s, mkExp("sat1", 5'b00000, 1, 0, 0, 1, 1));
    checkOutput();
    checkCounters("sat1", 32'hFFFF_FFFF, 0, 0);
    applyStimulus(s, mkExp("sat2", 5'b00000, 1, 0, 0, 1, 1));
    checkOutput();
    checkCounters("sat2", 32'hFFFF_FFFF, 0, 0);
    applyStimulus(memStim(0, 1, 1, 1, 1, 0), mkExp("sat_end", 5'b11111, 0, 0, 0, 1, 1));
    checkOutput();
    checkCounters("sat_end", 32'hFFFF_FFFF, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central stall/flush controller for the 5-stage RV32I pipeline. It drives the load enables of the PC and the four pipeline registers. It also arbitrates I-cache and D-cache waits, inserts the single load-use bubble the forwarding path cannot cover, and squashes wrong-path instructions on EX-resolved redirects. It owns the memory-wait flags and three 32-bit performance counters.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1 / rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- ex_br_redirect  in  1  EX resolved a taken branch, jal or jalr; fetch must redirect
- if_req  in  1  fetch stage requests an instruction this cycle
- imem_resp  in  1  I-cache response valid
- mem_req  in  1  MEM stage holds a load or store
- dmem_resp  in  1  D-cache response valid
- imem_read  out  1  permit/issue I-cache read
- dmem_go  out  1  permit/issue D-cache access
- load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1  register load enables
- bubble_id_ex  out  1  ID/EX loads a NOP (control fields zeroed)
- flush_if_id  out  1  IF/ID loads a NOP
- stall  out  1  pipeline frozen waiting on memory
- cnt_mem_stall, cnt_load_use, cnt_flush  out  CNT_W  performance counters

## Operation
- Registered flags i_done_q and d_done_q. Per-cycle terms:
  - i_done = imem_resp | i_done_q | !if_req
  - d_done = dmem_resp | d_done_q | !mem_req
  - advance = i_done & d_done
- imem_read = if_req & !i_done_q. dmem_go = mem_req & !d_done_q. A request is never reissued after its response has been latched.
- Not advance:
  - stall=1 and every load_* = 0.
  - i_done_q <= i_done. d_done_q <= d_done.
  - bubble_id_ex = flush_if_id = 0.
- Advance: both flags clear at the next edge. Then exactly one of the following applies, in priority order:
  - Redirect (ex_br_redirect=1): all load_* = 1, flush_if_id=1, bubble_id_ex=1.
  - Load-use hazard, defined as ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)): load_pc=0, load_if_id=0, load_id_ex=1 with bubble_id_ex=1, load_ex_mem=load_mem_wb=1.
  - Otherwise all load_* = 1, bubble_id_ex = flush_if_id = 0.
- A redirect or hazard asserted during a memory stall has no effect until the advance cycle. EX is frozen, so its inputs stay stable.
- Counters update at the edge after the cycle they count and saturate at all-ones (no wrap):
  - cnt_mem_stall +1 per cycle with stall=1.
  - cnt_load_use +1 per advance cycle that inserts a load-use bubble.
  - cnt_flush +1 per advance cycle with a redirect.
- Reset: while rst=1, every output is 0, including all load_*, imem_read, dmem_go, stall and the counters. Both flags clear. Reset mid-stall discards latched responses. The first cycle after rst falls is a normal evaluation.

## Timing
- Purely combinational path from imem_resp/dmem_resp/ex_* to load_*, stall, bubble and flush. The target is zero-cycle response: a same-cycle hit advances with no stall.
- Flags and counters are registered. A latched response affects outputs from the following cycle.
- I response in cycle N and D response in cycle N+k: stall for cycles N..N+k-1, advance in N+k. imem_read is low in N+1..N+k.
- Simultaneous imem_resp and dmem_resp in a stalled cycle give advance in that cycle.
- Load-use costs exactly 1 cycle. The next cycle the load is in MEM and forwarding takes over, so the hazard term is 0.

## Test plan
- Both caches hit every cycle, independent instructions, no redirect: all load_*=1, stall=0 for 20 cycles. All counters stay 0.
- if_req=1, imem_resp at cycle 3, mem_req=1, dmem_resp at cycle 6: stall=1 in cycles 0-5, imem_read=0 in cycles 4-6, advance in cycle 6. cnt_mem_stall=6.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, caches hit: load_pc=load_if_id=0, bubble_id_ex=1 for one cycle. cnt_load_use=1. The same case with ex_rd=0 produces no bubble.
- ex_br_redirect=1 together with a load-use hazard: redirect wins, flush_if_id=1, bubble_id_ex=1, load_pc=1. cnt_flush=1, cnt_load_use=0.
- ex_br_redirect=1 during a 4-cycle D-cache miss: no flush until the dmem_resp cycle, then one flush.
- rst asserted at cycle 2 of a stall after imem_resp has been latched: all outputs 0 during reset, imem_read=1 on the first cycle after release, counters 0.
- Counters preloaded near saturation (force) then stalled 3 cycles: cnt_mem_stall holds at all-ones.
